innerproduct_stream: RTL and testbench

//  Sequential, parametrised successor to the fixed 81-term combinational inner product.

---
 rtl/innerprod_pkg.sv | 27 ++
 rtl/innerprod_theta_ram.sv | 34 +++
 rtl/innerproduct_stream.sv | 176 +++++++++++++++++
 tb/tb_innerproduct_stream.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/innerprod_pkg.sv
// rtl/innerprod_pkg.sv - shared types, default widths and the lane product helper
package innerprod_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int N_FEAT_DEF     = 80;
  localparam int LANES_DEF      = 4;
  localparam int X_W_DEF        = 7;
  localparam int TH_W_DEF       = 16;
  localparam int ACC_W_DEF      = 32;
  localparam int BIAS_SHIFT_DEF = 16;

  // Unsigned feature times signed coefficient; callers truncate/extend to their accumulator width.
  function automatic logic signed [63:0] sext_prod(input logic [31:0] x,
                                                   input logic signed [31:0] theta);
    logic signed [63:0] xs;
    logic signed [63:0] ts;
    xs = {32'd0, x};
    ts = {{32{theta[31]}}, theta};
    return xs * ts;
  endfunction

endpackage

// File: rtl/innerprod_theta_ram.sv
// rtl/innerprod_theta_ram.sv - coefficient register file, one write port, bias plus per-lane async reads
module innerprod_theta_ram #(
  parameter int N_FEAT = 80,
  parameter int LANES  = 4,
  parameter int TH_W   = 16,
  parameter int AW     = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [TH_W-1:0]       wdata_i,
  input  logic [LANES*AW-1:0]   rd_addr_i,
  output logic [TH_W-1:0]       bias_rdata_o,
  output logic [LANES*TH_W-1:0] rd_data_o
);

  logic [TH_W-1:0] mem_q [0:N_FEAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= N_FEAT; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i <= AW'(N_FEAT))) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign bias_rdata_o = mem_q[0];

  for (genvar l = 0; l < LANES; l++) begin : g_rd
    assign rd_data_o[l*TH_W +: TH_W] = mem_q[rd_addr_i[l*AW +: AW]];
  end

endmodule

// File: rtl/innerproduct_stream.sv
// rtl/innerproduct_stream.sv - streaming multi-lane inner product with Q16 bias and result handshake
// Optional per-accumulate saturation and sat_flag output under INNERPROD_SAT_EN.
module innerproduct_stream
  import innerprod_pkg::*;
#(
  parameter int N_FEAT     = N_FEAT_DEF,
  parameter int LANES      = LANES_DEF,
  parameter int X_W        = X_W_DEF,
  parameter int TH_W       = TH_W_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int BIAS_SHIFT = BIAS_SHIFT_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         theta_we,
  input  logic [$clog2(N_FEAT+1)-1:0]  theta_addr,
  input  logic [TH_W-1:0]              theta_wdata,
  input  logic                         x_valid,
  output logic                         x_ready,
  input  logic [LANES*X_W-1:0]         x_data,
  output logic                         hidden_valid,
  input  logic                         hidden_ready,
`ifdef INNERPROD_SAT_EN
  output logic                         sat_flag,
`endif
  output logic [ACC_W-1:0]             hidden
);

  localparam int NBEATS = N_FEAT / LANES;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int AW     = $clog2(N_FEAT + 1);
`ifdef INNERPROD_SAT_EN
  localparam int SUM_W  = ACC_W + $clog2(LANES + 1) + 1;
`else
  localparam int SUM_W  = ACC_W;
`endif

  state_e                   state_q, state_d;
  logic [BW-1:0]            beat_q, beat_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  hidden_q, hidden_d;
  logic [LANES*AW-1:0]      rd_addr;
  logic [TH_W-1:0]          th_bias;
  logic [LANES*TH_W-1:0]    th_lane;
  logic signed [SUM_W-1:0]  lane_sum;
  logic signed [SUM_W-1:0]  base_w;
  logic signed [SUM_W-1:0]  sum_w;
  logic signed [ACC_W-1:0]  step;
`ifdef INNERPROD_SAT_EN
  logic                     sat_q, sat_d;
  logic                     clip;
`endif

  always_comb begin
    rd_addr = '0;
    for (int l = 0; l < LANES; l++)
      rd_addr[l*AW +: AW] = AW'(int'(beat_q) * LANES + l + 1);
  end

  innerprod_theta_ram #(
    .N_FEAT (N_FEAT),
    .LANES  (LANES),
    .TH_W   (TH_W),
    .AW     (AW)
  ) u_theta (
    .clk          (clk),
    .rst          (rst),
    .we_i         (theta_we && (state_q == IDLE)),
    .waddr_i      (theta_addr),
    .wdata_i      (theta_wdata),
    .rd_addr_i    (rd_addr),
    .bias_rdata_o (th_bias),
    .rd_data_o    (th_lane)
  );

  // The first beat of an image starts from the bias instead of the running sum.
  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++)
      lane_sum = lane_sum + SUM_W'(sext_prod(32'(x_data[l*X_W +: X_W]),
                                             32'($signed(th_lane[l*TH_W +: TH_W]))));
    base_w = (state_q == IDLE) ? (SUM_W'($signed(th_bias)) <<< BIAS_SHIFT) : SUM_W'(acc_q);
    sum_w  = base_w + lane_sum;
`ifdef INNERPROD_SAT_EN
    clip = (sum_w[SUM_W-1:ACC_W-1] != {(SUM_W-ACC_W+1){sum_w[SUM_W-1]}});
    if (!clip)
      step = sum_w[ACC_W-1:0];
    else if (sum_w[SUM_W-1])
      step = {1'b1, {(ACC_W-1){1'b0}}};
    else
      step = {1'b0, {(ACC_W-1){1'b1}}};
`else
    step = sum_w;
`endif
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    acc_d    = acc_q;
    hidden_d = hidden_q;
`ifdef INNERPROD_SAT_EN
    sat_d    = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (x_valid) begin
          acc_d = step;
`ifdef INNERPROD_SAT_EN
          sat_d = clip;
`endif
          if (NBEATS == 1) begin
            state_d  = DONE;
            hidden_d = step;
          end else begin
            state_d = ACCUM;
            beat_d  = BW'(1);
          end
        end
      end
      ACCUM: begin
        if (x_valid) begin
          acc_d = step;
`ifdef INNERPROD_SAT_EN
          sat_d = sat_q | clip;
`endif
          if (beat_q == BW'(NBEATS - 1)) begin
            state_d  = DONE;
            hidden_d = step;
            beat_d   = '0;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      DONE: begin
        if (hidden_ready) begin
          state_d = IDLE;
          beat_d  = '0;
`ifdef INNERPROD_SAT_EN
          sat_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      acc_q    <= '0;
      hidden_q <= '0;
`ifdef INNERPROD_SAT_EN
      sat_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      acc_q    <= acc_d;
      hidden_q <= hidden_d;
`ifdef INNERPROD_SAT_EN
      sat_q    <= sat_d;
`endif
    end
  end

  assign x_ready      = (state_q != DONE);
  assign hidden_valid = (state_q == DONE);
  assign hidden       = hidden_q;
`ifdef INNERPROD_SAT_EN
  assign sat_flag     = sat_q;
`endif

endmodule

// File: tb/tb_innerproduct_stream.sv
// tb/tb_innerproduct_stream.sv - scoreboard bench for innerproduct_stream (default params)
module tb_innerproduct_stream;

  localparam int N_FEAT = 80;
  localparam int LANES  = 4;
  localparam int NB     = N_FEAT / LANES;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst;
  logic        theta_we;
  logic [6:0]  theta_addr;
  logic [15:0] theta_wdata;
  logic        x_valid;
  logic        x_ready;
  logic [27:0] x_data;
  logic        hidden_valid;
  logic        hidden_ready;
  logic [31:0] hidden;
`ifdef INNERPROD_SAT_EN
  logic        sat_flag;
`endif

  int tests = 0;
  int fails = 0;
  int theta_m [0:N_FEAT];
  int xs [0:N_FEAT-1];
  logic [31:0] exp_q [$];
  logic        exp_sat_q [$];
  logic [31:0] got;

  always #5 clk = ~clk;

  innerproduct_stream #(
    .N_FEAT(80), .LANES(4), .X_W(7), .TH_W(16), .ACC_W(32), .BIAS_SHIFT(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .theta_we     (theta_we),
    .theta_addr   (theta_addr),
    .theta_wdata  (theta_wdata),
    .x_valid      (x_valid),
    .x_ready      (x_ready),
    .x_data       (x_data),
    .hidden_valid (hidden_valid),
    .hidden_ready (hidden_ready),
`ifdef INNERPROD_SAT_EN
    .sat_flag     (sat_flag),
`endif
    .hidden       (hidden)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
    end
  endtask

  task automatic push_expected();
    longint acc;
    logic   s;
    s   = 1'b0;
    acc = longint'(theta_m[0]) * 65536;
    for (int b = 0; b < NB; b++) begin
      for (int l = 0; l < LANES; l++)
        acc += longint'(xs[b*LANES+l]) * longint'(theta_m[b*LANES+l+1]);
`ifdef INNERPROD_SAT_EN
      if (acc > SMAX) begin acc = SMAX; s = 1'b1; end
      else if (acc < SMIN) begin acc = SMIN; s = 1'b1; end
`endif
    end
    exp_q.push_back(acc[31:0]);
    exp_sat_q.push_back(s);
  endtask

  task automatic load_theta(input int addr, input int val);
    theta_we    = 1'b1;
    theta_addr  = 7'(addr);
    theta_wdata = 16'(val);
    @(negedge clk);
    theta_we = 1'b0;
    theta_m[addr] = val;
  endtask

  task automatic load_all(input int b0, input int rest);
    load_theta(0, b0);
    for (int i = 1; i <= N_FEAT; i++) load_theta(i, rest);
  endtask

  task automatic drive_beat(input int b);
    int cnt;
    for (int l = 0; l < LANES; l++) x_data[l*7 +: 7] = 7'(xs[b*LANES+l]);
    x_valid = 1'b1;
    cnt = 0;
    while (!x_ready && cnt < 50) begin @(negedge clk); cnt++; end
    if (cnt >= 50) chk("beat_ready_timeout", {31'd0, x_ready}, 32'd1);
    @(negedge clk);
    x_valid  = 1'b0;
    theta_we = 1'b0;
  endtask

  // wr_beat: beat index on which a theta write rides along (-1 for none).
  task automatic send_image(input int bubble_pct, input int wr_beat, input int wr_addr, input int wr_val);
    push_expected();
    for (int b = 0; b < NB; b++) begin
      while (bubble_pct > 0 && $urandom_range(99) < bubble_pct) begin
        x_valid = 1'b0;
        @(negedge clk);
      end
      if (b == wr_beat) begin
        theta_we    = 1'b1;
        theta_addr  = 7'(wr_addr);
        theta_wdata = 16'(wr_val);
      end
      drive_beat(b);
    end
    if (wr_beat == 0) theta_m[wr_addr] = wr_val;
    chk("latency_valid", {31'd0, hidden_valid}, 32'd1);
  endtask

  task automatic collect(input int hold, input string tag, output logic [31:0] obs);
    int cnt;
    logic [31:0] e;
    logic        es;
    obs = '0;
    cnt = 0;
    while (!hidden_valid && cnt < 50) begin @(negedge clk); cnt++; end
    chk({tag, "_valid"}, {31'd0, hidden_valid}, 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() == 0) return;
    e  = exp_q.pop_front();
    es = exp_sat_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      hidden_ready = 1'b0;
      chk({tag, "_hold_hidden"}, hidden, e);
      chk({tag, "_hold_valid"}, {31'd0, hidden_valid}, 32'd1);
      chk({tag, "_hold_xready"}, {31'd0, x_ready}, 32'd0);
      @(negedge clk);
    end
    hidden_ready = 1'b1;
    obs = hidden;
    chk({tag, "_hidden"}, hidden, e);
`ifdef INNERPROD_SAT_EN
    chk({tag, "_sat"}, {31'd0, sat_flag}, {31'd0, es});
`else
    if (es) chk({tag, "_model_sat"}, 32'd0, 32'd1);
`endif
    @(negedge clk);
    hidden_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, hidden_valid}, 32'd0);
    chk({tag, "_xready_back"}, {31'd0, x_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; theta_we = 1'b0; theta_addr = '0; theta_wdata = '0;
    x_valid = 1'b0; x_data = '0; hidden_ready = 1'b0;
    for (int i = 0; i <= N_FEAT; i++) theta_m[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_hidden_valid", {31'd0, hidden_valid}, 32'd0);
    chk("rst_x_ready", {31'd0, x_ready}, 32'd1);
    chk("rst_hidden", hidden, 32'd0);
`ifdef INNERPROD_SAT_EN
    chk("rst_sat_flag", {31'd0, sat_flag}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // 1: bias 1.0, weights 2, x=3
    load_all(1, 2);
    for (int i = 0; i < N_FEAT; i++) xs[i] = 3;
    send_image(0, -1, 0, 0);
    collect(0, "t1", got);
    chk("t1_literal", got, 32'd66016);

    // 2: all -1, x=127
    load_all(-1, -1);
    for (int i = 0; i < N_FEAT; i++) xs[i] = 127;
    send_image(0, -1, 0, 0);
    collect(0, "t2", got);
    chk("t2_literal", got, 32'(-75696));

    // 3: bubbles and held result, then random data
    send_image(40, -1, 0, 0);
    collect(10, "t3", got);
    chk("t3_literal", got, 32'(-75696));
    for (int i = 0; i < N_FEAT; i++) xs[i] = int'($urandom_range(127));
    send_image(30, -1, 0, 0);
    collect(3, "t3r", got);

    // 4: writes in ACCUM ignored; IDLE write affects the next image; first-beat write uses old value
    for (int i = 0; i < N_FEAT; i++) xs[i] = 127;
    send_image(0, 3, 5, 100);
    collect(0, "t4a", got);
    chk("t4a_literal", got, 32'(-75696));
    load_theta(5, 100);
    send_image(0, -1, 0, 0);
    collect(0, "t4b", got);
    chk("t4b_literal", got, 32'(-62869));
    send_image(0, 0, 1, 50);
    collect(0, "t4c", got);
    chk("t4c_literal", got, 32'(-62869));
    send_image(0, -1, 0, 0);
    collect(0, "t4d", got);
    chk("t4d_literal", got, 32'(-56392));

    // 5: reset mid-image
    for (int b = 0; b < 8; b++) drive_beat(b);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i <= N_FEAT; i++) theta_m[i] = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_no_valid", {31'd0, hidden_valid}, 32'd0);
      chk("t5_x_ready", {31'd0, x_ready}, 32'd1);
      @(negedge clk);
    end
    for (int i = 0; i < N_FEAT; i++) xs[i] = int'($urandom_range(1, 127));
    send_image(0, -1, 0, 0);
    collect(0, "t5", got);
    chk("t5_literal", got, 32'd0);

    // 6: overflow
    load_all(32767, 32767);
    for (int i = 0; i < N_FEAT; i++) xs[i] = 127;
    send_image(0, -1, 0, 0);
    collect(0, "t6", got);
`ifdef INNERPROD_SAT_EN
    chk("t6_literal", got, 32'h7fffffff);
`else
    chk("t6_literal", got, 32'(-1814636464));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
